dino_game_ctrl: RTL and testbench

- Game-state controller directly downstream of the dinosaur jump renderer.
- Consumes the renderer's per-pixel `px` (dino sprite) together with the obstacle layer's pixel output.
- Detects dino/obstacle overlap within each frame and runs the IDLE/RUN/OVER state machine.
- Drives `game_status` back into the jump and obstacle units, and produces a BCD score for the score overlay.

---
 rtl/dino_pkg.sv | 20 ++
 rtl/dino_bcd_counter.sv | 52 +++++
 rtl/dino_game_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dino_game_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game controller and its neighbours.
// The obstacle unit imports the same frame constants so both agree on pacing.
package dino_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } game_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_NINE = 4'd9;

   localparam int DEF_SCORE_DIGITS     = 4;
   localparam int DEF_FRAMES_PER_POINT = 6;
   localparam int DEF_HIT_THRESHOLD    = 4;
   localparam int DEF_RESTART_HOLDOFF  = 30;

endpackage

// File: rtl/dino_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; sticks at all-nines.
module dino_bcd_counter
   import dino_pkg::*;
#(
   parameter int DIGITS = DEF_SCORE_DIGITS
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  clear,
   input  logic                  inc,
   output logic [4*DIGITS-1:0]   count,
   output logic                  saturated
);

   logic [4*DIGITS-1:0] count_d;
   logic                carry;
   bcd_digit_t          dig;

   // Ripple the +1 through the digits (9 -> 0 with carry) and flag all-nines.
   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      count_d   = count;
      carry     = 1'b1;
      saturated = 1'b1;
      dig       = '0;
      for (int i = 0; i < DIGITS; i++) begin
         dig = count[4*i +: 4];
         if (dig != BCD_NINE) begin
            saturated = 1'b0;
         end
         if (carry) begin
            if (dig == BCD_NINE) begin
               count_d[4*i +: 4] = '0;
            end else begin
               count_d[4*i +: 4] = dig + 4'd1;
               carry             = 1'b0;
            end
         end
      end
   end

   // Count register: clear wins over increment; no wrap past all-nines.
   // NOTE: state is updated with non-blocking assignments so all flops sample together.
   always_ff @(posedge CLK) begin
      if (RESET || clear) begin
         count <= '0;
      end else if (inc && !saturated) begin
         count <= count_d;
      end
   end

endmodule

// File: rtl/dino_game_ctrl.sv
// Game-state controller: collision detection, IDLE/RUN/OVER FSM and BCD score.
// Optional feature macro: DINO_HI_SCORE_EN adds a hi_score output kept across restarts.
module dino_game_ctrl
   import dino_pkg::*;
#(
   parameter int SCORE_DIGITS     = DEF_SCORE_DIGITS,
   parameter int FRAMES_PER_POINT = DEF_FRAMES_PER_POINT,
   parameter int HIT_THRESHOLD    = DEF_HIT_THRESHOLD,
   parameter int RESTART_HOLDOFF  = DEF_RESTART_HOLDOFF
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      fresh,
   input  logic                      visible,
   input  logic                      button_jump,
   input  logic                      dino_px,
   input  logic                      obstacle_px,
   output logic                      game_status,
   output logic                      game_over,
   output logic [4*SCORE_DIGITS-1:0] score
`ifdef DINO_HI_SCORE_EN
   ,
   output logic [4*SCORE_DIGITS-1:0] hi_score
`endif
);

   localparam int HC_W = $clog2(HIT_THRESHOLD + 1);
   localparam int HO_W = (RESTART_HOLDOFF > 0) ? $clog2(RESTART_HOLDOFF + 1) : 1;
   localparam int FC_W = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;

   localparam logic [HC_W-1:0] HIT_MAX = HC_W'(HIT_THRESHOLD);
   localparam logic [HO_W-1:0] HO_LOAD = HO_W'(RESTART_HOLDOFF);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_POINT - 1);

   game_state_t     state_q, state_d;
   logic            fresh_q, frame_end;
   logic            btn_meta, btn_sync, btn_prev, btn_rise;
   logic            start_req;
   logic [HC_W-1:0] hit_cnt;
   logic            hit;
   logic [FC_W-1:0] frame_cnt;
   logic            point_due;
   logic [HO_W-1:0] holdoff;
   logic            start_game, collide, score_inc, score_sat;

   // Frame boundary is the falling edge of fresh, matching the renderers.
   assign frame_end = fresh_q & ~fresh;
   assign btn_rise  = btn_sync & ~btn_prev;
   assign hit       = (hit_cnt >= HIT_MAX);
   assign point_due = (frame_cnt == FC_LAST);

   // Register the frame strobe, synchronize the button and latch one start request per press.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         fresh_q   <= 1'b0;
         btn_meta  <= 1'b0;
         btn_sync  <= 1'b0;
         btn_prev  <= 1'b0;
         start_req <= 1'b0;
      end else begin
         fresh_q   <= fresh;
         btn_meta  <= button_jump;
         btn_sync  <= btn_meta;
         btn_prev  <= btn_sync;
         // A press landing on frame_end itself survives into the next frame.
         start_req <= btn_rise | (start_req & ~frame_end);
      end
   end

   // Saturating count of overlapping dino/obstacle pixels within the current frame.
   always_ff @(posedge CLK) begin
      if (RESET || frame_end) begin
         hit_cnt <= '0;
      end else if (state_q == RUN && visible && dino_px && obstacle_px && hit_cnt != HIT_MAX) begin
         hit_cnt <= hit_cnt + 1'b1;
      end
   end

   // Next-state decode; every decision is taken only at frame_end.
   always_comb begin
      state_d    = state_q;
      start_game = 1'b0;
      collide    = 1'b0;
      score_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_end && start_req) begin
               state_d    = RUN;
               start_game = 1'b1;
            end
         end
         RUN: begin
            if (frame_end) begin
               if (hit) begin
                  state_d = OVER;
                  collide = 1'b1;
               end else begin
                  score_inc = point_due & ~score_sat;
               end
            end
         end
         OVER: begin
            if (frame_end && start_req && holdoff == '0) begin
               state_d    = RUN;
               start_game = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register plus registered status outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         game_status <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         state_q     <= state_d;
         game_status <= (state_d == RUN);
         game_over   <= collide;
      end
   end

   // Frames-per-point pacing in RUN and the restart holdoff in OVER.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         frame_cnt <= '0;
         holdoff   <= '0;
      end else begin
         if (start_game) begin
            frame_cnt <= '0;
         end else if (state_q == RUN && frame_end && !hit) begin
            frame_cnt <= point_due ? '0 : frame_cnt + 1'b1;
         end
         if (collide) begin
            holdoff <= HO_LOAD;
         end else if (state_q == OVER && frame_end && holdoff != '0) begin
            holdoff <= holdoff - 1'b1;
         end
      end
   end

   dino_bcd_counter #(
      .DIGITS (SCORE_DIGITS)
   ) u_score (
      .CLK       (CLK),
      .RESET     (RESET),
      .clear     (start_game),
      .inc       (score_inc),
      .count     (score),
      .saturated (score_sat)
   );

`ifdef DINO_HI_SCORE_EN
   // Best score, captured on RUN->OVER. Valid BCD orders the same as unsigned
   // binary, so a plain compare equals a digit-wise compare from the MSB.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         hi_score <= '0;
      end else if (collide && score > hi_score) begin
         hi_score <= score;
      end
   end
`endif

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed testbench for dino_game_ctrl. A second instance with one frame per
// point reaches the all-nines score boundary in a short run.
module tb_dino_game_ctrl;

   localparam int SD = 4;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          fresh = 1'b0;
   logic          visible = 1'b0;
   logic          button_jump = 1'b0;
   logic          dino_px = 1'b0;
   logic          obstacle_px = 1'b0;
   logic          game_status, game_over;
   logic [4*SD-1:0] score;

   logic          fresh_s = 1'b0;
   logic          button_s = 1'b0;
   logic          gs_s, go_s;
   logic [4*SD-1:0] score_s;

`ifdef DINO_HI_SCORE_EN
   logic [4*SD-1:0] hi_score, hi_score_s;
`endif

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   dino_game_ctrl #(
      .SCORE_DIGITS(SD), .FRAMES_PER_POINT(6), .HIT_THRESHOLD(4), .RESTART_HOLDOFF(30)
   ) dut (
      .CLK(CLK), .RESET(RESET), .fresh(fresh), .visible(visible),
      .button_jump(button_jump), .dino_px(dino_px), .obstacle_px(obstacle_px),
      .game_status(game_status), .game_over(game_over), .score(score)
`ifdef DINO_HI_SCORE_EN
      , .hi_score(hi_score)
`endif
   );

   dino_game_ctrl #(
      .SCORE_DIGITS(SD), .FRAMES_PER_POINT(1), .HIT_THRESHOLD(4), .RESTART_HOLDOFF(30)
   ) dut_sat (
      .CLK(CLK), .RESET(RESET), .fresh(fresh_s), .visible(1'b0),
      .button_jump(button_s), .dino_px(1'b0), .obstacle_px(1'b0),
      .game_status(gs_s), .game_over(go_s), .score(score_s)
`ifdef DINO_HI_SCORE_EN
      , .hi_score(hi_score_s)
`endif
   );

   // ---------------- stimulus helpers ----------------
   task automatic pixels(input int n_ovl, input int n_clean);
      for (int i = 0; i < n_ovl; i++) begin
         @(negedge CLK); visible = 1'b1; dino_px = 1'b1; obstacle_px = 1'b1;
      end
      for (int i = 0; i < n_clean; i++) begin
         @(negedge CLK); visible = 1'b1; dino_px = 1'b1; obstacle_px = 1'b0;
      end
   endtask

   // Returns inside the frame_end cycle, before the deciding edge.
   task automatic to_frame_end(input bit ovl_at_end);
      @(negedge CLK); visible = 1'b0; dino_px = 1'b0; obstacle_px = 1'b0; fresh = 1'b1;
      @(negedge CLK); fresh = 1'b0;
      if (ovl_at_end) begin
         visible = 1'b1; dino_px = 1'b1; obstacle_px = 1'b1;
      end
   endtask

   // Returns one cycle after the deciding edge, where outputs show the decision.
   task automatic after_frame_end();
      @(negedge CLK); visible = 1'b0; dino_px = 1'b0; obstacle_px = 1'b0;
   endtask

   task automatic frame(input int n_ovl);
      pixels(n_ovl, 2);
      to_frame_end(1'b0);
      after_frame_end();
   endtask

   task automatic press(input bit sat);
      @(negedge CLK);
      if (sat) button_s = 1'b1; else button_jump = 1'b1;
      repeat (4) @(negedge CLK);
      button_s = 1'b0; button_jump = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic sat_frame();
      @(negedge CLK); fresh_s = 1'b1;
      @(negedge CLK); fresh_s = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      checks++; if (game_status !== 1'b0) begin errors++; $display("FAIL reset_status: got %0b expected 0", game_status); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_over: got %0b expected 0", game_over); end
      checks++; if (score !== 16'h0000) begin errors++; $display("FAIL reset_score: got %h expected 0000", score); end
`ifdef DINO_HI_SCORE_EN
      checks++; if (hi_score !== 16'h0000) begin errors++; $display("FAIL reset_hi: got %h expected 0000", hi_score); end
`endif
      RESET = 1'b0;
      repeat (3) frame(0);
      checks++; if (game_status !== 1'b0) begin errors++; $display("FAIL idle_status: got %0b expected 0", game_status); end
      checks++; if (score !== 16'h0000) begin errors++; $display("FAIL idle_score: got %h expected 0000", score); end
      checks++; if (gs_s !== 1'b0) begin errors++; $display("FAIL sat_idle_status: got %0b expected 0", gs_s); end
   endtask

   task automatic test_start();
      press(1'b0);
      pixels(0, 2);
      to_frame_end(1'b0);
      checks++; if (game_status !== 1'b0) begin errors++; $display("FAIL start_early: got %0b expected 0", game_status); end
      after_frame_end();
      checks++; if (game_status !== 1'b1) begin errors++; $display("FAIL start_status: got %0b expected 1", game_status); end
      checks++; if (score !== 16'h0000) begin errors++; $display("FAIL start_score: got %h expected 0000", score); end
      for (int f = 1; f <= 12; f++) begin
         frame(0);
         if (f == 5) begin
            checks++; if (score !== 16'h0000) begin errors++; $display("FAIL score_f5: got %h expected 0000", score); end
         end
         if (f == 6) begin
            checks++; if (score !== 16'h0001) begin errors++; $display("FAIL score_f6: got %h expected 0001", score); end
         end
      end
      checks++; if (score !== 16'h0002) begin errors++; $display("FAIL score_f12: got %h expected 0002", score); end
   endtask

   task automatic test_collision();
      // 3 overlaps plus one on the frame_end cycle (dropped) -> no collision.
      pixels(3, 2);
      to_frame_end(1'b1);
      after_frame_end();
      checks++; if (game_status !== 1'b1) begin errors++; $display("FAIL ovl3_status: got %0b expected 1", game_status); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL ovl3_over: got %0b expected 0", game_over); end
      // hit count must restart each frame: 2 more is still below threshold.
      frame(2);
      checks++; if (game_status !== 1'b1) begin errors++; $display("FAIL ovl2_status: got %0b expected 1", game_status); end
      pixels(4, 2);
      to_frame_end(1'b0);
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL hit_early: got %0b expected 0", game_over); end
      after_frame_end();
      checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL hit_pulse: got %0b expected 1", game_over); end
      checks++; if (game_status !== 1'b0) begin errors++; $display("FAIL hit_status: got %0b expected 0", game_status); end
      checks++; if (score !== 16'h0002) begin errors++; $display("FAIL hit_score: got %h expected 0002", score); end
`ifdef DINO_HI_SCORE_EN
      checks++; if (hi_score !== 16'h0002) begin errors++; $display("FAIL hit_hi: got %h expected 0002", hi_score); end
`endif
      @(negedge CLK);
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL hit_pulse_end: got %0b expected 0", game_over); end
   endtask

   task automatic test_holdoff();
      for (int f = 1; f <= 31; f++) begin
         if (f == 10 || f == 30 || f == 31) press(1'b0);
         frame(0);
         if (f == 10) begin
            checks++; if (game_status !== 1'b0) begin errors++; $display("FAIL holdoff_f10: got %0b expected 0", game_status); end
         end
         if (f == 30) begin
            checks++; if (game_status !== 1'b0) begin errors++; $display("FAIL holdoff_f30: got %0b expected 0", game_status); end
            checks++; if (score !== 16'h0002) begin errors++; $display("FAIL over_score_held: got %h expected 0002", score); end
         end
      end
      checks++; if (game_status !== 1'b1) begin errors++; $display("FAIL restart_status: got %0b expected 1", game_status); end
      checks++; if (score !== 16'h0000) begin errors++; $display("FAIL restart_score: got %h expected 0000", score); end
   endtask

   task automatic test_reset_mid_run();
      repeat (252) frame(0);
      checks++; if (score !== 16'h0042) begin errors++; $display("FAIL score_42: got %h expected 0042", score); end
      @(negedge CLK); RESET = 1'b1;
      @(negedge CLK);
      checks++; if (game_status !== 1'b0) begin errors++; $display("FAIL midrst_status: got %0b expected 0", game_status); end
      checks++; if (score !== 16'h0000) begin errors++; $display("FAIL midrst_score: got %h expected 0000", score); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL midrst_over: got %0b expected 0", game_over); end
`ifdef DINO_HI_SCORE_EN
      checks++; if (hi_score !== 16'h0000) begin errors++; $display("FAIL midrst_hi: got %h expected 0000", hi_score); end
`endif
      RESET = 1'b0;
   endtask

   task automatic test_hi_score();
      press(1'b0);
      frame(0);
      checks++; if (game_status !== 1'b1) begin errors++; $display("FAIL hi_start: got %0b expected 1", game_status); end
      repeat (90) frame(0);
      checks++; if (score !== 16'h0015) begin errors++; $display("FAIL score_15: got %h expected 0015", score); end
      frame(4);
      checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL end15_pulse: got %0b expected 1", game_over); end
`ifdef DINO_HI_SCORE_EN
      checks++; if (hi_score !== 16'h0015) begin errors++; $display("FAIL hi_15: got %h expected 0015", hi_score); end
`endif
      repeat (30) frame(0);
      press(1'b0);
      frame(0);
      checks++; if (game_status !== 1'b1) begin errors++; $display("FAIL replay_status: got %0b expected 1", game_status); end
      frame(4);
      checks++; if (score !== 16'h0000) begin errors++; $display("FAIL replay_score: got %h expected 0000", score); end
`ifdef DINO_HI_SCORE_EN
      checks++; if (hi_score !== 16'h0015) begin errors++; $display("FAIL hi_kept: got %h expected 0015", hi_score); end
`endif
   endtask

   task automatic test_saturation();
      press(1'b1);
      sat_frame();
      @(negedge CLK);
      checks++; if (gs_s !== 1'b1) begin errors++; $display("FAIL sat_start: got %0b expected 1", gs_s); end
      repeat (9998) sat_frame();
      @(negedge CLK);
      checks++; if (score_s !== 16'h9998) begin errors++; $display("FAIL sat_9998: got %h expected 9998", score_s); end
      sat_frame();
      @(negedge CLK);
      checks++; if (score_s !== 16'h9999) begin errors++; $display("FAIL sat_9999: got %h expected 9999", score_s); end
      repeat (11) sat_frame();
      @(negedge CLK);
      checks++; if (score_s !== 16'h9999) begin errors++; $display("FAIL sat_hold: got %h expected 9999", score_s); end
      checks++; if (go_s !== 1'b0) begin errors++; $display("FAIL sat_over: got %0b expected 0", go_s); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_start();
      test_collision();
      test_holdoff();
      test_reset_mid_run();
      test_hi_score();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
